// File: rtl/sram_controller.sv
// Sequences one 32-bit pipeline access into two 16-bit async-SRAM half-accesses (low, then high).
// Optional SRAM_STATS_EN adds saturating rd_count/wr_count outputs.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] low_half_q, low_half_d;
  logic [31:0] read_data_q, read_data_d;

  logic [31:0] offset;
  logic        half;
  logic        unused_offset;

  // Out-of-range addresses wrap: only the low word-index bits reach the bus.
  assign offset        = addr_q - 32'(BASE_ADDR);
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign half          = (state_q == StHigh);
  assign read_data     = read_data_q;

`ifdef SRAM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    low_half_d  = low_half_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
`ifdef SRAM_STATS_EN
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
`endif

    unique case (state_q)
      StIdle: begin
        ready = ~rd_en & ~wr_en;
        if (rd_en | wr_en) begin
          addr_d  = address;
          wdata_d = write_data;
          is_wr_d = wr_en;
          cnt_d   = '0;
          state_d = StLow;
        end
      end
      StLow, StHigh: begin
        sram_addr = {offset[SRAM_AW:2], half};
        if (is_wr_q) begin
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
          sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = half ? StDone : StHigh;
          if (!is_wr_q) begin
            if (half) read_data_d = {sram_dq_in, low_half_q};
            else      low_half_d  = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
`ifdef SRAM_STATS_EN
        if (is_wr_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        if (!is_wr_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      low_half_q  <= '0;
      read_data_q <= '0;
`ifdef SRAM_STATS_EN
      rd_count_q  <= '0;
      wr_count_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      low_half_q  <= low_half_d;
      read_data_q <= read_data_d;
`ifdef SRAM_STATS_EN
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: one controller with 2-cycle half-accesses plus a small SRAM model,
// and one with 1-cycle half-accesses for back-to-back reads.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instance A: ACCESS_CYCLES = 2
  logic        a_rst, a_rd_en, a_wr_en, a_ready, a_oe, a_we_n;
  logic [31:0] a_address, a_write_data, a_read_data;
  logic [17:0] a_sram_addr;
  logic [15:0] a_dq_out, a_dq_in;
  logic [15:0] mem_a [256];

  // Instance B: ACCESS_CYCLES = 1, read-only SRAM image
  logic        b_rst, b_rd_en, b_wr_en, b_ready, b_oe, b_we_n;
  logic [31:0] b_address, b_write_data, b_read_data;
  logic [17:0] b_sram_addr;
  logic [15:0] b_dq_out, b_dq_in;
  logic [15:0] mem_b [256];

`ifdef SRAM_STATS_EN
  logic [15:0] a_rd_count, a_wr_count, b_rd_count, b_wr_count;
`endif

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2), .SRAM_AW(18)) u_dut_a (
    .clk        (clk),
    .rst        (a_rst),
    .rd_en      (a_rd_en),
    .wr_en      (a_wr_en),
    .address    (a_address),
    .write_data (a_write_data),
    .read_data  (a_read_data),
    .ready      (a_ready),
    .sram_addr  (a_sram_addr),
    .sram_dq_out(a_dq_out),
    .sram_dq_in (a_dq_in),
    .sram_dq_oe (a_oe),
    .sram_we_n  (a_we_n)
`ifdef SRAM_STATS_EN
    ,
    .rd_count   (a_rd_count),
    .wr_count   (a_wr_count)
`endif
  );

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(1), .SRAM_AW(18)) u_dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .rd_en      (b_rd_en),
    .wr_en      (b_wr_en),
    .address    (b_address),
    .write_data (b_write_data),
    .read_data  (b_read_data),
    .ready      (b_ready),
    .sram_addr  (b_sram_addr),
    .sram_dq_out(b_dq_out),
    .sram_dq_in (b_dq_in),
    .sram_dq_oe (b_oe),
    .sram_we_n  (b_we_n)
`ifdef SRAM_STATS_EN
    ,
    .rd_count   (b_rd_count),
    .wr_count   (b_wr_count)
`endif
  );

  assign a_dq_in = mem_a[a_sram_addr[7:0]];
  assign b_dq_in = mem_b[b_sram_addr[7:0]];

  always @(posedge clk) begin
    if (!a_we_n && a_oe) mem_a[a_sram_addr[7:0]] <= a_dq_out;
  end

  // Per-cycle log of one access on instance A; index 0 is the request cycle.
  logic [31:0] log_addr [16];
  logic [15:0] log_dq   [16];
  logic        log_rdy  [16];
  int          we_cnt, oe_cnt;

  // Entered at a negedge with A idle; returns #1 into the DONE cycle.
  task automatic run_a(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int chg_at, output int lat);
    a_rd_en = rd; a_wr_en = wr; a_address = addr; a_write_data = wd;
    lat = -1; we_cnt = 0; oe_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == chg_at) begin
        a_address    = 32'h0000_2000;
        a_write_data = 32'hFFFF_FFFF;
      end
      #1;
      log_addr[i] = 32'(a_sram_addr);
      log_dq[i]   = a_dq_out;
      log_rdy[i]  = a_ready;
      if (!a_we_n) we_cnt++;
      if (a_oe) oe_cnt++;
      if (i > 0 && a_ready) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    a_rd_en = 1'b0; a_wr_en = 1'b0;
  endtask

  int          lat;
  logic [7:0]  rdy_pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'(i * 16'h0101 + 16'h1000);
    end
    a_rst = 1'b1; a_rd_en = 1'b0; a_wr_en = 1'b0; a_address = '0; a_write_data = '0;
    b_rst = 1'b1; b_rd_en = 1'b0; b_wr_en = 1'b0; b_address = '0; b_write_data = '0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    check_eq("rst_ready", 32'(a_ready), 32'd1);
    check_eq("rst_we_n", 32'(a_we_n), 32'd1);
    check_eq("rst_oe", 32'(a_oe), 32'd0);
    check_eq("rst_rdata", a_read_data, 32'h0);
    check_eq("rst_addr", 32'(a_sram_addr), 32'h0);
    check_eq("rst_dq", 32'(a_dq_out), 32'h0);
    @(negedge clk);

    // Write DEADBEEF at 1024
    run_a(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, -1, lat);
    check_eq("wr_latency", lat, 32'd5);
    check_eq("wr_rdy_t0", 32'(log_rdy[0]), 32'd0);
    check_eq("wr_lo_addr", log_addr[1], 32'd0);
    check_eq("wr_lo_dq", 32'(log_dq[2]), 32'h0000_BEEF);
    check_eq("wr_hi_addr", log_addr[4], 32'd1);
    check_eq("wr_hi_dq", 32'(log_dq[3]), 32'h0000_DEAD);
    check_eq("wr_we_cycles", we_cnt, 32'd4);
    check_eq("wr_oe_cycles", oe_cnt, 32'd4);
    check_eq("wr_mem_lo", 32'(mem_a[0]), 32'h0000_BEEF);
    check_eq("wr_mem_hi", 32'(mem_a[1]), 32'h0000_DEAD);
    check_eq("wr_rdata_kept", a_read_data, 32'h0);
    @(negedge clk);

    // Read it back
    run_a(1'b1, 1'b0, 32'd1024, 32'h0, -1, lat);
    check_eq("rd_latency", lat, 32'd5);
    check_eq("rd_we_cycles", we_cnt, 32'd0);
    check_eq("rd_data", a_read_data, 32'hDEAD_BEEF);
    @(negedge clk);

    // Address mapping
    run_a(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, -1, lat);
    check_eq("map_lo", log_addr[1], 32'd4);
    check_eq("map_hi", log_addr[3], 32'd5);
    @(negedge clk);

    // Simultaneous read and write: write wins
    run_a(1'b1, 1'b1, 32'd1040, 32'h1234_5678, -1, lat);
    check_eq("both_we_cycles", we_cnt, 32'd4);
    check_eq("both_rdata", a_read_data, 32'hDEAD_BEEF);
    check_eq("both_mem_lo", 32'(mem_a[8]), 32'h0000_5678);
    check_eq("both_mem_hi", 32'(mem_a[9]), 32'h0000_1234);
    @(negedge clk);

    // Inputs change at first HIGH cycle; latched values must persist
    run_a(1'b0, 1'b1, 32'd1048, 32'hA5A5_5A5A, 3, lat);
    check_eq("busy_hi_addr", log_addr[3], 32'd13);
    check_eq("busy_hi_addr2", log_addr[4], 32'd13);
    check_eq("busy_hi_dq", 32'(log_dq[4]), 32'h0000_A5A5);
    check_eq("busy_mem_hi", 32'(mem_a[13]), 32'h0000_A5A5);
    @(negedge clk);

    // Reset during the first HIGH cycle of a write
    a_wr_en = 1'b1; a_address = 32'd1024; a_write_data = 32'h1111_2222;
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_in_high", 32'(a_sram_addr), 32'd1);
    a_rst = 1'b1; a_wr_en = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mid_rst_we_n", 32'(a_we_n), 32'd1);
    check_eq("mid_rst_oe", 32'(a_oe), 32'd0);
    check_eq("mid_rst_ready", 32'(a_ready), 32'd1);
    check_eq("mid_rst_rdata", a_read_data, 32'h0);
    a_rst = 1'b0;
    @(negedge clk);

    // Back-to-back reads with one-cycle half-accesses
    b_rd_en = 1'b1; b_address = 32'd1024;
    rdy_pat = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      rdy_pat = {rdy_pat[6:0], b_ready};
      if (i == 3) begin
        check_eq("b2b_rd0", b_read_data, {mem_b[1], mem_b[0]});
        b_address = 32'd1028;
      end
      if (i == 7) begin
        check_eq("b2b_rd1", b_read_data, {mem_b[3], mem_b[2]});
        b_rd_en = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("b2b_ready_pat", 32'(rdy_pat), 32'h0000_0011);
    check_eq("b2b_we_idle", 32'(b_we_n), 32'd1);
`ifdef SRAM_STATS_EN
    check_eq("stat_rd", 32'(b_rd_count), 32'd2);
    check_eq("stat_wr", 32'(b_wr_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
